// File: rtl/cmp_serial_izq_der.sv
// ============================================================================
// Module      : cmp_serial_izq_der
// Description : Bit-serial MSB-first magnitude comparator (lt/eq/gt + N flag).
//               Optional macro CMP_LE_SEL_EN adds input n so that N = lt | (n & eq).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_serial_izq_der #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
`ifdef CMP_LE_SEL_EN
    input  logic n,
`endif
    output logic bit_ready,
    output logic busy,
    output logic done,
    output logic lt,
    output logic eq,
    output logic gt,
    output logic N
);

    localparam int              c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_DECIDED = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cntNext;
    logic              r_ltFlag, r_eqFlag, r_gtFlag;
    logic              w_ltNext, w_eqNext, w_gtNext;
    logic              w_beat;
    logic              w_scanNext;
    logic              w_leSel;

    // bit_ready is high exactly in SCAN/DECIDED, so it qualifies the handshake
    assign w_beat = bit_valid & bit_ready;

    always_comb begin
        w_nextState = r_state;
        w_cntNext   = r_cnt;
        w_ltNext    = r_ltFlag;
        w_eqNext    = r_eqFlag;
        w_gtNext    = r_gtFlag;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_SCAN;
                    w_cntNext   = '0;
                    w_ltNext    = 1'b0;
                    w_eqNext    = 1'b1;
                    w_gtNext    = 1'b0;
                end
            end
            S_SCAN: begin
                if (w_beat) begin
                    w_cntNext = r_cnt + 1'b1;
                    if (a_bit != b_bit) begin
                        w_ltNext    = ~a_bit & b_bit;
                        w_gtNext    = a_bit & ~b_bit;
                        w_eqNext    = 1'b0;
                        w_nextState = S_DECIDED;
                    end
                    // last beat wins even if it was also the deciding one
                    if (r_cnt == c_LAST) begin
                        w_nextState = S_DONE;
                    end
                end
            end
            S_DECIDED: begin
                if (w_beat) begin
                    w_cntNext = r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        w_nextState = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    w_nextState = S_SCAN;
                    w_cntNext   = '0;
                    w_ltNext    = 1'b0;
                    w_eqNext    = 1'b1;
                    w_gtNext    = 1'b0;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    assign w_scanNext = (w_nextState == S_SCAN) || (w_nextState == S_DECIDED);

`ifdef CMP_LE_SEL_EN
    logic r_leSel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leSel <= 1'b0;
        end else if (start && ((r_state == S_IDLE) || (r_state == S_DONE))) begin
            r_leSel <= n;
        end
    end

    assign w_leSel = r_leSel;
`else
    assign w_leSel = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ltFlag  <= 1'b0;
            r_eqFlag  <= 1'b1;
            r_gtFlag  <= 1'b0;
            bit_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b1;
            gt        <= 1'b0;
            N         <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_cntNext;
            r_ltFlag  <= w_ltNext;
            r_eqFlag  <= w_eqNext;
            r_gtFlag  <= w_gtNext;
            bit_ready <= w_scanNext;
            busy      <= w_scanNext;
            done      <= (w_nextState == S_DONE);
            // visible results change only on entry to DONE
            if (w_nextState == S_DONE) begin
                lt <= w_ltNext;
                eq <= w_eqNext;
                gt <= w_gtNext;
                N  <= w_ltNext | (w_leSel & w_eqNext);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cmp_serial_izq_der.sv
// ============================================================================
// Module      : tb_cmp_serial_izq_der
// Description : Scoreboard bench for the serial MSB-first comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_serial_izq_der;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n, start, bit_valid, a_bit, b_bit, n;
    logic bit_ready, busy, done, lt, eq, gt, N;

    int nVec = 0;
    int nErr = 0;
    int cyc  = 0;

    typedef struct {
        logic lt;
        logic eq;
        logic gt;
        logic N;
        int   cyc;
    } exp_t;

    exp_t expQ[$];

    cmp_serial_izq_der #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
`ifdef CMP_LE_SEL_EN
        .n         (n),
`endif
        .bit_ready (bit_ready),
        .busy      (busy),
        .done      (done),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt),
        .N         (N)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every done pulse
    always @(negedge clk) begin
        if (rst_n) begin
            check("onehot_lt_eq_gt", int'(lt) + int'(eq) + int'(gt), 1);
            check("busy_eq_ready", int'(busy), int'(bit_ready));
            if (done) begin
                check("busy_low_in_done", int'(busy), 0);
                if (expQ.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("lt", int'(lt), int'(e.lt));
                    check("eq", int'(eq), int'(e.eq));
                    check("gt", int'(gt), int'(e.gt));
                    check("N",  int'(N),  int'(e.N));
                end
            end
        end
    end

    // Reference: plain integer comparison of the whole words
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic nSel, input int doneCyc);
        exp_t e;
        e.lt  = (a < b);
        e.eq  = (a == b);
        e.gt  = (a > b);
`ifdef CMP_LE_SEL_EN
        e.N   = (a < b) || (nSel && (a == b));
`else
        e.N   = (a < b);
`endif
        e.cyc = doneCyc;
        return e;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that enters DONE.
    task automatic runTxn(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] bub, input bit spur, input bit nSel);
        start = 1'b1;
        n     = nSel;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (bub[i]) begin
                bit_valid = 1'b0;
                @(posedge clk); #1;
            end
            bit_valid = 1'b1;
            a_bit     = a[W-1-i];
            b_bit     = b[W-1-i];
            start     = spur && (i == 2);
            check("bit_ready_in_beat", int'(bit_ready), 1);
            if (i == W - 1) expQ.push_back(model(a, b, nSel, cyc + 1));
            @(posedge clk); #1;
            start = 1'b0;
        end
        bit_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_bit_ready"}, int'(bit_ready), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_lt"}, int'(lt), 0);
        check({tag, "_eq"}, int'(eq), 1);
        check({tag, "_gt"}, int'(gt), 0);
        check({tag, "_N"}, int'(N), 0);
    endtask

    task automatic resetMid(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        n     = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            a_bit     = a[W-1-i];
            b_bit     = b[W-1-i];
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        check("busy_before_abort", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (W + 3) idle();
        checkResetOutputs("after_abort");
    endtask

    initial begin
        logic [W-1:0] ra, rb, rbub;
        bit           rchain;
        rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0;
        a_bit = 1'b0; b_bit = 1'b0; n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        idle();

        runTxn(8'h5A, 8'h5B, 8'h00, 1'b0, 1'b0); idle();
        runTxn(8'h80, 8'h7F, 8'h00, 1'b0, 1'b0); idle();
        runTxn(8'hC3, 8'hC3, 8'h24, 1'b0, 1'b0); idle();
        runTxn(8'hC3, 8'hC3, 8'h24, 1'b0, 1'b1); idle();
        runTxn(8'h12, 8'h34, 8'h00, 1'b1, 1'b0);
        runTxn(8'h01, 8'h02, 8'h00, 1'b0, 1'b0); idle();
        resetMid(8'h0F, 8'hF0);
        runTxn(8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0); idle();

        for (int t = 0; t < 40; t++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            rbub   = W'($urandom & $urandom & $urandom);
            rchain = ($urandom_range(0, 1) == 1);
            runTxn(ra, rb, rbub, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
            if (!rchain) idle();
        end

        repeat (4) idle();
        check("scoreboard_drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
